// File: rtl/controlador_display_multiplexado.sv
// Time-multiplexed seven-segment driver with shadow/active value registers and frame-aligned updates.
// Optional leading-zero blanking is compiled in when BLANCO_CEROS_EN is defined.
module controlador_display_multiplexado #(
  parameter int DIGITOS     = 4,
  parameter int PRESCALA    = 50000,
  parameter int ANODO_COMUN = 1
) (
  input  logic                   Reloj,
  input  logic                   Reset_n,
  input  logic [4*DIGITOS-1:0]   Dato,
  input  logic                   Cargar,
  input  logic                   Habilitar,
  output logic [6:0]             Segmentos,
  output logic [DIGITOS-1:0]     Anodos,
  output logic                   Actualizado
);

  localparam int PW = $clog2(PRESCALA);
  localparam int IW = (DIGITOS > 1) ? $clog2(DIGITOS) : 1;
  localparam logic [6:0]         SEG_OFF = (ANODO_COMUN != 0) ? 7'h7F : 7'h00;
  localparam logic [DIGITOS-1:0] AN_OFF  = (ANODO_COMUN != 0) ? {DIGITOS{1'b1}} : {DIGITOS{1'b0}};

  logic [PW-1:0]          presc_q, presc_d;
  logic [IW-1:0]          indice_q, indice_d;
  logic [4*DIGITOS-1:0]   shadow_q, shadow_d;
  logic [4*DIGITOS-1:0]   activo_q, activo_d;
  logic                   pendiente_q, pendiente_d;
  logic                   actualizado_q, actualizado_d;
  logic [6:0]             seg_q, seg_d;
  logic [DIGITOS-1:0]     an_q, an_d;

  logic                   tick, fin_trama;
  logic [3:0]             nibble;
  logic [6:0]             seg_bajo;
  logic [DIGITOS-1:0]     un_caliente;
  logic [DIGITOS-1:0]     visible;

  // Decode table is stored active-low; inverted below for common-cathode boards.
  function automatic logic [6:0] decodificar(input logic [3:0] n);
    case (n)
      4'h0:    decodificar = 7'h40;
      4'h1:    decodificar = 7'h79;
      4'h2:    decodificar = 7'h24;
      4'h3:    decodificar = 7'h30;
      4'h4:    decodificar = 7'h19;
      4'h5:    decodificar = 7'h12;
      4'h6:    decodificar = 7'h02;
      4'h7:    decodificar = 7'h78;
      4'h8:    decodificar = 7'h00;
      4'h9:    decodificar = 7'h18;
      4'hA:    decodificar = 7'h08;
      4'hB:    decodificar = 7'h03;
      4'hC:    decodificar = 7'h46;
      4'hD:    decodificar = 7'h21;
      4'hE:    decodificar = 7'h06;
      4'hF:    decodificar = 7'h0E;
      default: decodificar = 7'h7F;
    endcase
  endfunction

  assign tick      = Habilitar && (presc_q == PW'(PRESCALA - 1));
  assign fin_trama = tick && (indice_q == IW'(DIGITOS - 1));

`ifdef BLANCO_CEROS_EN
  logic hay_mayor;
  always_comb begin
    visible   = '0;
    hay_mayor = 1'b0;
    for (int i = DIGITOS - 1; i >= 0; i--) begin
      hay_mayor  = hay_mayor | (activo_q[4*i +: 4] != 4'h0);
      visible[i] = hay_mayor || (i == 0);
    end
  end
`else
  assign visible = {DIGITOS{1'b1}};
`endif

  always_comb begin
    presc_d       = presc_q;
    indice_d      = indice_q;
    shadow_d      = shadow_q;
    activo_d      = activo_q;
    pendiente_d   = pendiente_q;
    actualizado_d = 1'b0;

    if (Habilitar) begin
      presc_d = tick ? '0 : presc_q + PW'(1);
    end
    if (tick) begin
      indice_d = (indice_q == IW'(DIGITOS - 1)) ? '0 : indice_q + IW'(1);
    end

    if (Cargar) begin
      shadow_d    = Dato;
      pendiente_d = 1'b1;
    end
    // A load landing on the frame end bypasses the shadow so it is not delayed a whole frame.
    if (fin_trama && Cargar) begin
      activo_d      = Dato;
      pendiente_d   = 1'b0;
      actualizado_d = 1'b1;
    end else if (fin_trama && pendiente_q) begin
      activo_d      = shadow_q;
      pendiente_d   = 1'b0;
      actualizado_d = 1'b1;
    end
  end

  always_comb begin
    nibble                = activo_q[{indice_q, 2'b00} +: 4];
    seg_bajo              = decodificar(nibble);
    un_caliente           = '0;
    un_caliente[indice_q] = 1'b1;
    seg_d                 = SEG_OFF;
    an_d                  = AN_OFF;
    if (Habilitar && visible[indice_q]) begin
      seg_d = (ANODO_COMUN != 0) ? seg_bajo : ~seg_bajo;
      an_d  = (ANODO_COMUN != 0) ? ~un_caliente : un_caliente;
    end
  end

  always_ff @(posedge Reloj or negedge Reset_n) begin
    if (!Reset_n) begin
      presc_q       <= '0;
      indice_q      <= '0;
      shadow_q      <= '0;
      activo_q      <= '0;
      pendiente_q   <= 1'b0;
      actualizado_q <= 1'b0;
      seg_q         <= SEG_OFF;
      an_q          <= AN_OFF;
    end else begin
      presc_q       <= presc_d;
      indice_q      <= indice_d;
      shadow_q      <= shadow_d;
      activo_q      <= activo_d;
      pendiente_q   <= pendiente_d;
      actualizado_q <= actualizado_d;
      seg_q         <= seg_d;
      an_q          <= an_d;
    end
  end

  assign Segmentos   = seg_q;
  assign Anodos      = an_q;
  assign Actualizado = actualizado_q;

endmodule

// File: tb/tb_controlador_display_multiplexado.sv
// Bench for controlador_display_multiplexado: cycle model feeding an expected-value queue,
// plus a table of display values and hand sequences for frame-end load, blanking-off and async reset.
module tb_controlador_display_multiplexado;

  localparam int DIG = 4;
  localparam int PRE = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] dato;
  logic        cargar;
  logic        hab;
  logic [6:0]  Segmentos;
  logic [3:0]  Anodos;
  logic        Actualizado;

  controlador_display_multiplexado #(.DIGITOS(DIG), .PRESCALA(PRE), .ANODO_COMUN(1)) dut (
    .Reloj(clk), .Reset_n(rst_n), .Dato(dato), .Cargar(cargar), .Habilitar(hab),
    .Segmentos(Segmentos), .Anodos(Anodos), .Actualizado(Actualizado)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [6:0] seg;
    logic [3:0] an;
    logic       upd;
  } exp_t;

  typedef struct {
    logic            doble;
    logic [15:0]     primero;
    logic [15:0]     valor;
    logic [3:0][6:0] seg;
  } vec_t;

  exp_t       cola[$];
  vec_t       tabla[5];
  logic [6:0] dec_tab[16];

  int vectores = 0;
  int fallos   = 0;

  int          m_pre, m_idx;
  logic [15:0] m_act, m_sh;
  logic        m_pend;

  logic [6:0] s_seg;
  logic [3:0] s_an;
  logic       s_upd;

  task automatic modelo_reset();
    m_pre = 0; m_idx = 0; m_act = '0; m_sh = '0; m_pend = 1'b0;
  endtask

  task automatic chk(input string nombre, input logic [15:0] got, input logic [15:0] req);
    vectores++;
    if (got !== req) begin
      fallos++;
      $display("FAIL %s at t=%0t: got %h, expected %h", nombre, $time, got, req);
    end
  endtask

  // Drives one cycle of stimulus, pushes the model's prediction, then pops it against the DUT.
  task automatic ciclo(input logic c, input logic [15:0] d, input logic h);
    exp_t e;
    exp_t r;
    logic tick, fe, lit;
    cargar = c; dato = d; hab = h;
    if (!rst_n) begin
      modelo_reset();
      e = '{seg: 7'h7F, an: 4'hF, upd: 1'b0};
    end else begin
      lit = 1'b1;
`ifdef BLANCO_CEROS_EN
      lit = (m_idx == 0) || ((m_act >> (4 * m_idx)) != 16'h0);
`endif
      tick  = h && (m_pre == PRE - 1);
      fe    = tick && (m_idx == DIG - 1);
      e.seg = (h && lit) ? dec_tab[m_act[4*m_idx +: 4]] : 7'h7F;
      e.an  = (h && lit) ? ~(4'b0001 << m_idx) : 4'hF;
      e.upd = fe && (c || m_pend);
      if (fe && c) begin
        m_act = d; m_pend = 1'b0;
      end else if (fe && m_pend) begin
        m_act = m_sh; m_pend = 1'b0;
      end else if (c) begin
        m_pend = 1'b1;
      end
      if (c) m_sh = d;
      if (h) m_pre = (m_pre == PRE - 1) ? 0 : m_pre + 1;
      if (tick) m_idx = (m_idx == DIG - 1) ? 0 : m_idx + 1;
    end
    cola.push_back(e);
    @(posedge clk);
    #1;
    s_seg = Segmentos; s_an = Anodos; s_upd = Actualizado;
    r = cola.pop_front();
    vectores++;
    if ({s_seg, s_an, s_upd} !== {r.seg, r.an, r.upd}) begin
      fallos++;
      $display("FAIL scoreboard t=%0t: got seg=%h an=%h upd=%b, expected seg=%h an=%h upd=%b",
               $time, s_seg, s_an, s_upd, r.seg, r.an, r.upd);
    end
  endtask

  task automatic alinear(input int pre, input int idx, input logic usar_idx);
    int n = 0;
    while (n < 40 && !(m_pre == pre && (!usar_idx || m_idx == idx))) begin
      ciclo(1'b0, 16'h0, 1'b1);
      n++;
    end
    chk("align", {15'b0, (n < 40)}, 16'd1);
  endtask

  task automatic esperar_upd();
    int n = 0;
    do begin
      ciclo(1'b0, 16'h0, 1'b1);
      n++;
    end while (!s_upd && n < 40);
    chk("upd_seen", {15'b0, s_upd}, 16'd1);
  endtask

  initial begin
    int n_upd;
    logic [3:0] an_antes;
    dec_tab = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                7'h00, 7'h18, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
    tabla[0] = '{1'b0, 16'h0000, 16'h12AF, {7'h79, 7'h24, 7'h08, 7'h0E}};
    tabla[1] = '{1'b1, 16'h1111, 16'h2222, {7'h24, 7'h24, 7'h24, 7'h24}};
    tabla[2] = '{1'b0, 16'h0000, 16'h3456, {7'h30, 7'h19, 7'h12, 7'h02}};
    tabla[3] = '{1'b0, 16'h0000, 16'h789A, {7'h78, 7'h00, 7'h18, 7'h08}};
    tabla[4] = '{1'b0, 16'h0000, 16'hEDCB, {7'h06, 7'h21, 7'h46, 7'h03}};

    rst_n = 1'b0; cargar = 1'b0; dato = '0; hab = 1'b1;
    modelo_reset();
    #12;
    chk("reset_seg", {9'b0, Segmentos}, 16'h7F);
    chk("reset_an", {12'b0, Anodos}, 16'hF);
    chk("reset_upd", {15'b0, Actualizado}, 16'h0);
    ciclo(1'b0, 16'h0, 1'b1);
    ciclo(1'b0, 16'h0, 1'b1);
    #3 rst_n = 1'b1;

    // First frame after reset: every slot shows 0.
    for (int k = 0; k < 16; k++) begin
      ciclo(1'b0, 16'h0, 1'b1);
`ifndef BLANCO_CEROS_EN
      chk("frame0_seg", {9'b0, s_seg}, 16'h40);
      chk("frame0_an", {12'b0, s_an}, {12'b0, ~(4'b0001 << (k / 4))});
`else
      if (k < 4) chk("frame0_seg", {9'b0, s_seg}, 16'h40);
`endif
    end

    for (int v = 0; v < 5; v++) begin
      alinear(1, 1, 1'b1);
      if (tabla[v].doble) begin
        ciclo(1'b1, tabla[v].primero, 1'b1);
        ciclo(1'b0, 16'h0, 1'b1);
      end
      ciclo(1'b1, tabla[v].valor, 1'b1);
      esperar_upd();
      n_upd = 0;
      for (int k = 0; k < 16; k++) begin
        ciclo(1'b0, 16'h0, 1'b1);
        n_upd += s_upd;
        chk("tab_seg", {9'b0, s_seg}, {9'b0, tabla[v].seg[k / 4]});
        chk("tab_an", {12'b0, s_an}, {12'b0, ~(4'b0001 << (k / 4))});
      end
      chk("upd_once", n_upd[15:0], 16'd0);
    end

    // Load coincident with the frame-end cycle.
    alinear(PRE - 1, DIG - 1, 1'b1);
    ciclo(1'b1, 16'h0005, 1'b1);
    chk("fe_load_upd", {15'b0, s_upd}, 16'd1);
    for (int k = 0; k < 16; k++) begin
      ciclo(1'b0, 16'h0, 1'b1);
`ifdef BLANCO_CEROS_EN
      chk("fe_load_an", {12'b0, s_an}, (k < 4) ? 16'hE : 16'hF);
      if (k < 4) chk("fe_load_seg", {9'b0, s_seg}, 16'h12);
`else
      chk("fe_load_an", {12'b0, s_an}, {12'b0, ~(4'b0001 << (k / 4))});
      chk("fe_load_seg", {9'b0, s_seg}, (k < 4) ? 16'h12 : 16'h40);
`endif
    end

    // Habilitar low for 10 cycles mid-slot; scan resumes where it stopped.
    alinear(1, 0, 1'b0);
    an_antes = s_an;
    for (int k = 0; k < 10; k++) begin
      ciclo(1'b0, 16'h0, 1'b0);
      chk("hold_seg", {9'b0, s_seg}, 16'h7F);
      chk("hold_an", {12'b0, s_an}, 16'hF);
    end
    ciclo(1'b0, 16'h0, 1'b1);
    chk("resume_an", {12'b0, s_an}, {12'b0, an_antes});
    for (int k = 0; k < 12; k++) ciclo(1'b0, 16'h0, 1'b1);

    // Asynchronous reset between edges with a load pending.
    alinear(1, 1, 1'b1);
    ciclo(1'b1, 16'h9999, 1'b1);
    #3 rst_n = 1'b0;
    #1;
    chk("async_seg", {9'b0, Segmentos}, 16'h7F);
    chk("async_an", {12'b0, Anodos}, 16'hF);
    chk("async_upd", {15'b0, Actualizado}, 16'h0);
    modelo_reset();
    ciclo(1'b0, 16'h0, 1'b1);
    #3 rst_n = 1'b1;
    n_upd = 0;
    for (int k = 0; k < 24; k++) begin
      ciclo(1'b0, 16'h0, 1'b1);
      n_upd += s_upd;
      if (k < 4) chk("lost_load_seg", {9'b0, s_seg}, 16'h40);
    end
    chk("lost_load_upd", n_upd[15:0], 16'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectores, fallos);
    $finish;
  end

endmodule
